// File: rtl/async_fifo_pkg.sv
// async_fifo_pkg: shared helpers for the async FIFO controllers
// clog2, pointer-width derivation (AW+1) and Gray/binary conversion on 32-bit values.
package async_fifo_pkg;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int ptr_width(input int aw);
    return aw + 1;
  endfunction
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/ptr_sync_2ff.sv
// ptr_sync_2ff: two-flop synchronizer for a Gray pointer crossing clock domains
// Ports: clk, rst (sync active-high), d (async input), q (synchronized output).
module ptr_sync_2ff #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;
  always_ff @(posedge clk)
    if (rst) {q, meta} <= '0;
    else     {q, meta} <= {meta, d};
endmodule

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: async FIFO read-side controller with FWFT valid/ready output
// Ports: rd_clk/rd_rst (sync active-high); wr_ptr_gray in, rd_ptr_gray out;
// RAM read port ram_rd_en/ram_rd_addr/ram_rd_data (1-cycle read latency);
// stream rd_valid/rd_ready/rd_data; rd_empty; rd_level only with ASYNC_FIFO_RD_LEVEL_EN.
module fifo_rd_ctrl
  import async_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  localparam int AW = clog2(DEPTH),
  localparam int PW = ptr_width(AW)
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic [PW-1:0]         wr_ptr_gray,
  output logic [PW-1:0]         rd_ptr_gray,
  output logic                  ram_rd_en,
  output logic [AW-1:0]         ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_empty
`ifdef ASYNC_FIFO_RD_LEVEL_EN
  ,
  output logic [PW-1:0]         rd_level
`endif
);
  logic [PW-1:0] wr_sync, rd_bin, rd_bin_nxt;
  logic [1:0] out_cnt, cnt_pop;
  logic pending, pop;
  logic [DATA_WIDTH-1:0] buf1;

  ptr_sync_2ff #(.W(PW)) u_sync (
    .clk(rd_clk),
    .rst(rd_rst),
    .d  (wr_ptr_gray),
    .q  (wr_sync)
  );

  assign rd_empty    = rd_ptr_gray == wr_sync;
  assign rd_valid    = out_cnt != 2'd0;
  assign pop         = rd_valid && rd_ready;
  assign cnt_pop     = out_cnt - 2'(pop);
  // pending counts toward occupancy so an in-flight word always has a slot
  assign ram_rd_en   = !rd_rst && !rd_empty && ({1'b0, cnt_pop} + 3'(pending)) < 3'd2;
  assign ram_rd_addr = rd_bin[AW-1:0];
  assign rd_bin_nxt  = rd_bin + 1'b1;

  // rd_data is the head entry; buf1 holds the second word when two are buffered
  always_ff @(posedge rd_clk)
    if (rd_rst) begin
      rd_bin      <= '0;
      rd_ptr_gray <= '0;
      out_cnt     <= '0;
      pending     <= 1'b0;
      rd_data     <= '0;
      buf1        <= '0;
    end else begin
      pending <= ram_rd_en;
      if (ram_rd_en) begin
        rd_bin      <= rd_bin_nxt;
        rd_ptr_gray <= PW'(bin2gray(32'(rd_bin_nxt)));
      end
      out_cnt <= cnt_pop + 2'(pending);
      rd_data <= pending && cnt_pop == 2'd0 ? ram_rd_data : pop ? buf1 : rd_data;
      buf1    <= pending && cnt_pop != 2'd0 ? ram_rd_data : buf1;
    end

`ifdef ASYNC_FIFO_RD_LEVEL_EN
  always_ff @(posedge rd_clk)
    rd_level <= rd_rst ? '0 : PW'(gray2bin(32'(wr_sync))) - rd_bin;
`endif
endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-side controller of the async FIFO, running entirely in the read clock domain. It synchronizes the write pointer, detects empty, and drives the read port of the dual-port RAM. It presents the data to the consumer as a first-word-fall-through valid/ready stream and returns its Gray read pointer to the write domain.

## Interface
- DATA_WIDTH, 8, word width; must match the RAM.
- DEPTH, 16, number of RAM words; must be a power of 2, ≥ 4.
- AW, derived as clog2(DEPTH), address width. PW = AW+1, pointer width with wrap bit.

- rd_clk  in  1  read-domain clock; the only clock.
- rd_rst  in  1  synchronous, active-high reset.
- wr_ptr_gray  in  PW  Gray write pointer from the write domain; asynchronous to rd_clk.
- rd_ptr_gray  out  PW  registered Gray read pointer, sent to the write domain.
- ram_rd_en  out  1  RAM read strobe (issue).
- ram_rd_addr  out  AW  RAM read address.
- ram_rd_data  in  DATA_WIDTH  RAM registered output; valid in the cycle after ram_rd_en.
- rd_valid  out  1  output word available.
- rd_ready  in  1  consumer accepts the word; a pop occurs when rd_valid && rd_ready.
- rd_data  out  DATA_WIDTH  output word.
- rd_empty  out  1  no unread words remain in the RAM (in-flight and buffered words excluded).
- rd_level  out  PW  RAM occupancy; present only with ASYNC_FIFO_RD_LEVEL_EN.

## Operation
- **Write-pointer sync:** wr_ptr_gray passes through a 2-flop synchronizer, giving wr_sync. The sync flops are reset to 0.
- **Read pointer:** rd_bin (PW bits) is binary; rd_ptr_gray is registered and equals rd_bin ^ (rd_bin >> 1). ram_rd_addr = rd_bin[AW-1:0].
- **Empty:** rd_empty = (rd_ptr_gray == wr_sync). It is combinational from registers.
- **Output buffer:** a 2-entry FIFO (out_cnt 0..2) plus a pending flag meaning "a read was issued last cycle".
- **Issue:**
  - ram_rd_en = !rd_rst && !rd_empty && (out_cnt + pending − pop) < 2.
  - On issue, rd_bin increments and wraps modulo 2^PW.
- **Capture:** when pending is 1, ram_rd_data is written into the output buffer at the end of that cycle.
- **Output:** rd_valid = (out_cnt != 0); rd_data = head entry.
  - A word is never dropped or duplicated.
  - While rd_valid && !rd_ready, rd_data is stable.
- **Simultaneous events:** pop, capture and issue may all occur in the same cycle. Sustained throughput is 1 word per cycle.
- **Arithmetic:** pointer compare uses the full PW bits, so wrap-around is handled by the MSB. The level is computed as gray-to-binary(wr_sync) − rd_bin, modulo 2^PW.

## Timing
- **Reset values:**
  - rd_bin, rd_ptr_gray, sync flops, out_cnt, pending, rd_data: 0.
  - rd_valid = 0, ram_rd_en = 0, rd_empty = 1, rd_level = 0.
- **Reset mid-operation:** buffered and in-flight words are discarded; outputs return to reset values after the reset edge. The write side must be reset in the same reset sequence.
- **Latency:** a wr_ptr_gray change becomes visible in wr_sync after 2 edges. The issue is registered at edge 3 and capture occurs at edge 4, so rd_valid = 1 after the 4th rising edge.
- **Pointer update:** rd_ptr_gray updates at the edge that registers the issue, so a RAM slot is released to the write domain at issue time.
- **Back-pressure:** no issue occurs while out_cnt + pending − pop ≥ 2, which prevents buffer overflow.

## Configuration
- ASYNC_FIFO_RD_LEVEL_EN defined: the rd_level port and its subtractor exist, and rd_level is registered (1-cycle lag behind the pointers).
- ASYNC_FIFO_RD_LEVEL_EN undefined: the rd_level port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package async_fifo_pkg holds:
  - clog2 function;
  - bin2gray and gray2bin functions;
  - pointer-width derivation (AW+1).
- Sub-module ptr_sync_2ff: parameterized 2-flop synchronizer (width PW, clock rd_clk, reset rd_rst). The write-side controller reuses the same module.

## Test plan
Common settings: DATA_WIDTH=8, DEPTH=8, PW=4.
- **Reset:** assert rd_rst for 2 cycles → rd_valid=0, rd_empty=1, rd_ptr_gray=4'b0000, ram_rd_en=0.
- **Single word, held:** RAM[0]=0xA5; wr_ptr_gray=4'b0001; rd_ready=0 → exactly one issue at address 0; rd_valid=1 after the 4th edge with rd_data=0xA5, held stable; rd_ptr_gray=4'b0001.
- **Streaming:** RAM[0..7]=0x00..0x07; wr_ptr_gray=gray(8)=4'b1100; rd_ready=1 → words 0x00..0x07 popped on 8 consecutive cycles; afterwards rd_empty=1 and rd_ptr_gray=4'b1100.
- **Back-pressure:** same load with rd_ready pattern 1,0,0,1,0,1,1… → popped sequence is exactly 0x00..0x07; ram_rd_en is never high when out_cnt + pending − pop would reach 3.
- **Wrap:** two rounds of 8 words → rd_bin goes 15→0; rd_ptr_gray goes 4'b1000→4'b0000; data stays in order with no spurious empty or extra issue.
- **Reset mid-stream and level:**
  - Assert rd_rst with 2 words buffered → rd_valid=0 and ptr=0 on the next cycle.
  - With ASYNC_FIFO_RD_LEVEL_EN, wr_sync=gray(5) and rd_bin=2 → rd_level=3.
